// File: rtl/reg_file_mp.sv
// Multi-read-port register file with byte-masked writes, write-to-read bypass
// and a self-clearing sequence that zeroes every entry after reset.
module reg_file_mp #(
  parameter int WORDSIZE  = 32,
  parameter int BLOCKSIZE = 32,
  parameter int NREAD     = 2,
  parameter bit ZERO_REG  = 1'b0,
  parameter int ADDRSIZE  = $clog2(BLOCKSIZE)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      WE,
  input  logic [WORDSIZE/8-1:0]     WBE,
  input  logic [ADDRSIZE-1:0]       AW,
  input  logic [WORDSIZE-1:0]       D,
  input  logic [NREAD*ADDRSIZE-1:0] AR,
  output logic [NREAD*WORDSIZE-1:0] Q,
  output logic                      BUSY
);

  localparam int                  NBYTES = WORDSIZE / 8;
  localparam logic [ADDRSIZE:0]   DEPTH  = (ADDRSIZE + 1)'(BLOCKSIZE);
  localparam logic [ADDRSIZE-1:0] LAST   = ADDRSIZE'(BLOCKSIZE - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                    r_state, w_stateNext;
  logic [ADDRSIZE-1:0]       r_ccnt, w_ccntNext;
  logic [WORDSIZE-1:0]       r_mem [BLOCKSIZE];
  logic [NREAD*WORDSIZE-1:0] r_q, w_qNext;
  logic                      w_wrValid;
  logic [WORDSIZE-1:0]       w_wrOld, w_wrMerged;

  // Out-of-range addresses and (optionally) entry 0 behave as read-zero, write-ignore.
  function automatic logic addrValid(input logic [ADDRSIZE-1:0] a);
    return ({1'b0, a} < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= CLEAR;
      r_ccnt  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_ccnt  <= w_ccntNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_ccntNext  = r_ccnt;
    if (r_state == CLEAR) begin
      w_ccntNext = r_ccnt + ADDRSIZE'(1);
      if (r_ccnt == LAST) begin
        w_stateNext = READY;
        w_ccntNext  = '0;
      end
    end
  end

  assign BUSY = (r_state == CLEAR);

  // The merged word feeds both the array and any read port bypassing this write.
  always_comb begin
    w_wrValid  = WE && (r_state == READY) && addrValid(AW);
    w_wrOld    = '0;
    if (addrValid(AW)) begin
      w_wrOld = r_mem[AW];
    end
    w_wrMerged = w_wrOld;
    for (int k = 0; k < NBYTES; k++) begin
      if (WBE[k]) begin
        w_wrMerged[8*k +: 8] = D[8*k +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (r_state == CLEAR) begin
        r_mem[r_ccnt] <= '0;
      end else if (w_wrValid) begin
        r_mem[AW] <= w_wrMerged;
      end
    end
  end

  always_comb begin
    w_qNext = '0;
    for (int i = 0; i < NREAD; i++) begin
      if ((r_state == READY) && addrValid(AR[i*ADDRSIZE +: ADDRSIZE])) begin
        if (w_wrValid && (AR[i*ADDRSIZE +: ADDRSIZE] == AW)) begin
          w_qNext[i*WORDSIZE +: WORDSIZE] = w_wrMerged;
        end else begin
          w_qNext[i*WORDSIZE +: WORDSIZE] = r_mem[AR[i*ADDRSIZE +: ADDRSIZE]];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= '0;
    end else begin
      r_q <= w_qNext;
    end
  end

  assign Q = r_q;

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter WORDSIZE, default 32: data word width in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter BLOCKSIZE, default 32: number of storage entries; SHALL be at least 2 and need not be a power of two.
REQ-003 Parameter NREAD, default 2: number of independent read ports; SHALL be at least 1.
REQ-004 Parameter ZERO_REG, default 0: when 1, entry 0 is hardwired to zero.
REQ-005 Parameter ADDRSIZE, default $clog2(BLOCKSIZE): address width; it is derived and SHALL NOT be overridden.
REQ-006 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-007 RST  in  1  synchronous active-high reset.
REQ-008 WE  in  1  write enable.
REQ-009 WBE  in  WORDSIZE/8  byte write enables; bit k selects D[8k+7:8k].
REQ-010 AW  in  ADDRSIZE  write address.
REQ-011 D  in  WORDSIZE  write data.
REQ-012 AR  in  NREAD*ADDRSIZE  read addresses, flattened; port i occupies AR[i*ADDRSIZE +: ADDRSIZE].
REQ-013 Q  out  NREAD*WORDSIZE  registered read data, flattened; port i occupies Q[i*WORDSIZE +: WORDSIZE].
REQ-014 BUSY  out  1  high while the array is being cleared; writes are ignored and reads return zero.

Function
REQ-015 Control FSM SHALL have two states, CLEAR and READY, plus a clear counter CCNT of width ADDRSIZE.
REQ-016 While RST=1: state=CLEAR, CCNT=0, BUSY=1, all Q=0; no entry is written.
REQ-017 In CLEAR with RST=0: entry CCNT SHALL be written to 0 and CCNT incremented by 1 each cycle.
REQ-018 When CCNT=BLOCKSIZE-1 is cleared, the next state SHALL be READY; BUSY goes low on that same edge.
REQ-019 Consequently, BUSY SHALL be high for exactly BLOCKSIZE cycles after the first rising edge with RST=0.
REQ-020 In CLEAR, WE SHALL be ignored and every Q port SHALL register 0.
REQ-021 In READY with WE=1: for each k with WBE[k]=1, byte k of entry AW SHALL take byte k of D; bytes with WBE[k]=0 SHALL be unchanged.
REQ-022 WE=1 with WBE all zero SHALL leave memory unchanged.
REQ-023 Read latency SHALL be 1 cycle: Q port i at edge n+1 reflects AR port i sampled at edge n.
REQ-024 Write-to-read bypass: if WE=1 in READY and AR[i]==AW in the same cycle, Q[i] SHALL register the merged word (enabled bytes from D, others from the old entry), not the stale entry.
REQ-025 Multiple read ports SHALL read the same address simultaneously, each independently bypassed.
REQ-026 ZERO_REG=1: writes to address 0 SHALL be discarded, reads of address 0 SHALL return 0, and no bypass SHALL apply to address 0.
REQ-027 An address >= BLOCKSIZE SHALL be invalid: a write to it is discarded, and a read of it returns 0.
REQ-028 RST asserted mid-clear or mid-operation SHALL restart CLEAR from CCNT=0 on the next edge; entries already cleared remain 0.

Reset
REQ-029 Reset-visible values: BUSY=1, Q=0, state=CLEAR, CCNT=0.
REQ-030 Memory contents are not reset directly; they become all-zero only on completion of CLEAR.

Verification
REQ-031 Clear timing (BLOCKSIZE=32): RST=1 for 3 cycles, then 0 -> BUSY stays high 32 cycles then drops; reads of addresses 0..31 return 0x00000000.
REQ-032 Byte-masked write: write AW=5, D=0xAABBCCDD, WBE=4'b1111; then D=0x11223344, WBE=4'b0101 -> AR0=5 returns 0xAA22CC44 one cycle later.
REQ-033 Bypass across ports (NREAD=2): entry 7=0x12345678; same cycle WE=1, AW=7, D=0xFFFFFFFF, WBE=4'b0011, AR0=AR1=7 -> Q0=Q1=0x1234FFFF next cycle.
REQ-034 Zero register (ZERO_REG=1): write 0xDEADBEEF to address 0 while reading AR0=0 -> Q0=0 that cycle and thereafter.
REQ-035 Write during BUSY: write 0xCAFEF00D to AW=3 at the 10th BUSY cycle -> entry 3 reads 0 after BUSY falls.
REQ-036 Reset mid-clear, then invalid address (BLOCKSIZE=20): assert RST at CCNT=10 -> BUSY lasts 20 further cycles; then write AW=25 -> AR0=25 returns 0 and entries 0..19 are unchanged.
